// File: rtl/mem_load_pkg.sv
// mem_load_pkg: shared states, depths and address widths for mem_load_controller
package mem_load_pkg;
  localparam int WORD_W = 16;
  localparam int RJ_DEPTH = 16;
  localparam int COEFF_DEPTH = 512;
  localparam int X_DEPTH = 256;
  localparam int ZERO_LIMIT = 800;
  localparam int RJ_AW = 4;
  localparam int COEFF_AW = 9;
  localparam int X_AW = 8;
  localparam int ZERO_CNT_W = 10;
  localparam int BIT_CNT_W = 5;
  typedef enum logic [2:0] {IDLE, LOAD_RJ, LOAD_COEFF, WORKING, SLEEPING} load_state_t;
endpackage

// File: rtl/mem_load_controller_sipo_word.sv
// sipo_word: MSB-first serial-to-parallel word with Frame resync and word_done on the last bit
module sipo_word
  import mem_load_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame,
  input  logic              bit_en,
  input  logic              din,
  output logic [WORD_W-1:0] word_next,
  output logic              word_done
);
  logic [WORD_W-2:0] sh;
  logic [BIT_CNT_W-1:0] cnt;
  always_comb begin
    word_next = {sh, din};
    word_done = bit_en && !frame && cnt == BIT_CNT_W'(WORD_W - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh <= '0;
      cnt <= '0;
    end else if (bit_en && (frame || cnt != '0)) begin
      sh <= word_next[WORD_W-2:0];
      cnt <= frame ? BIT_CNT_W'(1) : word_done ? '0 : cnt + BIT_CNT_W'(1);
    end
endmodule

// File: rtl/mem_load_controller.sv
// mem_load_controller: loads rj, coeff and sample memories from two serial channels; MEM_LOAD_SLEEP_EN enables all-zero sleep
module mem_load_controller
  import mem_load_pkg::*;
(
  input  logic                Sclk,
  input  logic                Clear_n,
  input  logic                Frame,
  input  logic                bit_en,
  input  logic                InputL,
  input  logic                InputR,
  output logic [WORD_W-1:0]   rjL_wdata,
  output logic [WORD_W-1:0]   rjR_wdata,
  output logic [RJ_AW-1:0]    rj_waddr,
  output logic                rj_we,
  output logic [WORD_W-1:0]   coeff_wdataL,
  output logic [WORD_W-1:0]   coeff_wdataR,
  output logic [COEFF_AW-1:0] coeff_waddr,
  output logic                coeff_we,
  output logic [WORD_W-1:0]   inL_wdata,
  output logic [WORD_W-1:0]   inR_wdata,
  output logic [X_AW-1:0]     in_waddr,
  output logic                in_we,
  output logic                en_FIR,
  output logic                sleep_flag,
  output logic [2:0]          load_state
);
  load_state_t state;
  logic [WORD_W-1:0] word_l, word_r;
  logic done_l, done_r, done;
  sipo_word u_sipo_l (.clk(Sclk), .rst_n(Clear_n), .frame(Frame), .bit_en, .din(InputL), .word_next(word_l), .word_done(done_l));
  sipo_word u_sipo_r (.clk(Sclk), .rst_n(Clear_n), .frame(Frame), .bit_en, .din(InputR), .word_next(word_r), .word_done(done_r));
  assign done = done_l & done_r;
  assign load_state = state;
`ifdef MEM_LOAD_SLEEP_EN
  logic zero;
  logic [ZERO_CNT_W-1:0] zero_cnt;
  assign zero = ~|{word_l, word_r};
`else
  assign sleep_flag = 1'b0;
`endif
  always_ff @(posedge Sclk or negedge Clear_n)
    if (!Clear_n) begin
      state <= IDLE;
      rjL_wdata <= '0;
      rjR_wdata <= '0;
      rj_waddr <= '0;
      rj_we <= 1'b0;
      coeff_wdataL <= '0;
      coeff_wdataR <= '0;
      coeff_waddr <= '0;
      coeff_we <= 1'b0;
      inL_wdata <= '0;
      inR_wdata <= '0;
      in_waddr <= '0;
      in_we <= 1'b0;
      en_FIR <= 1'b0;
`ifdef MEM_LOAD_SLEEP_EN
      sleep_flag <= 1'b0;
      zero_cnt <= '0;
`endif
    end else begin
      rj_we <= 1'b0;
      coeff_we <= 1'b0;
      in_we <= 1'b0;
      en_FIR <= in_we;
      if (rj_we) rj_waddr <= rj_waddr + RJ_AW'(1);
      if (coeff_we) coeff_waddr <= coeff_waddr + COEFF_AW'(1);
      if (in_we) in_waddr <= in_waddr + X_AW'(1);
      case (state)
        IDLE: if (Frame && bit_en) state <= LOAD_RJ;
        LOAD_RJ: begin
          if (done) begin
            rj_we <= 1'b1;
            rjL_wdata <= word_l;
            rjR_wdata <= word_r;
          end
          if (rj_we && rj_waddr == RJ_AW'(RJ_DEPTH - 1)) state <= LOAD_COEFF;
        end
        LOAD_COEFF: begin
          if (done) begin
            coeff_we <= 1'b1;
            coeff_wdataL <= word_l;
            coeff_wdataR <= word_r;
          end
          if (coeff_we && coeff_waddr == COEFF_AW'(COEFF_DEPTH - 1)) state <= WORKING;
        end
        WORKING: begin
          if (done) begin
            in_we <= 1'b1;
            inL_wdata <= word_l;
            inR_wdata <= word_r;
`ifdef MEM_LOAD_SLEEP_EN
            zero_cnt <= !zero ? '0 : zero_cnt == ZERO_CNT_W'(ZERO_LIMIT) ? zero_cnt : zero_cnt + ZERO_CNT_W'(1);
`endif
          end
`ifdef MEM_LOAD_SLEEP_EN
          if (in_we && zero_cnt == ZERO_CNT_W'(ZERO_LIMIT)) begin
            state <= SLEEPING;
            sleep_flag <= 1'b1;
          end
`endif
        end
`ifdef MEM_LOAD_SLEEP_EN
        SLEEPING: if (done && !zero) begin
          in_we <= 1'b1;
          inL_wdata <= word_l;
          inR_wdata <= word_r;
          zero_cnt <= '0;
          sleep_flag <= 1'b0;
          state <= WORKING;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mem_load_controller.md
Name: mem_load_controller

Overview:
- Front-end writer that feeds the FIR datapath memories that the ALU controller reads.
- Deserialises two serial channels (L/R), MSB first, 16-bit words framed by Frame.
- Loads the rj memory (16 words), then the coefficient memory (512 words), then streams input samples into the 256-entry circular input memory.
- Per sample, issues the en_FIR pulse and drives sleep_flag (all-zero input detection) consumed by the ALU controller.

Parameters:
- WORD_W, 16, serial word width
- RJ_DEPTH, 16, rj words per channel
- COEFF_DEPTH, 512, coefficient words per channel
- X_DEPTH, 256, input sample ring depth
- ZERO_LIMIT, 800, consecutive all-zero samples (both channels) before sleep

Ports:
- Sclk  in  1  single clock, all logic on rising edge
- Clear_n  in  1  asynchronous active-low reset
- Frame  in  1  high with first (MSB) bit of each word
- bit_en  in  1  qualifies InputL/InputR this cycle
- InputL  in  1  serial data, left
- InputR  in  1  serial data, right
- rjL_wdata, rjR_wdata  out  16  rj write data
- rj_waddr  out  4  rj write address (shared L/R)
- rj_we  out  1  rj write strobe
- coeff_wdataL, coeff_wdataR  out  16  coefficient write data
- coeff_waddr  out  9  coefficient write address
- coeff_we  out  1  coefficient write strobe
- inL_wdata, inR_wdata  out  16  sample write data
- in_waddr  out  8  sample write address
- in_we  out  1  sample write strobe
- en_FIR  out  1  one-cycle "new sample ready" pulse
- sleep_flag  out  1  sleep indication
- load_state  out  3  current FSM state (debug)

Behaviour:
- Reset (Clear_n=0, async): all outputs 0, FSM=IDLE, bit counter 0, addresses 0, zero_cnt 0. Deassertion is synchronised by the environment.
- Deserialiser: on bit_en=1, shift the bit in MSB first. Frame=1 with bit_en=1 restarts the bit counter at 1, discarding any partial word. word_done fires on the cycle the 16th bit is captured. Bits with bit_en=1 before the first Frame are ignored.
- Write strobes (rj_we/coeff_we/in_we) are registered. Each is high exactly one cycle, the cycle after word_done, with address and data stable in that cycle.
- IDLE: first Frame -> LOAD_RJ.
- LOAD_RJ: each word_done writes rj[rj_waddr]. After the write at address RJ_DEPTH-1 -> LOAD_COEFF, with coeff_waddr=0.
- LOAD_COEFF: each word_done writes coeff. After the write at address COEFF_DEPTH-1 -> WORKING, with in_waddr=0.
- WORKING, word_done, sample nonzero on either channel:
  - write in[in_waddr] (in_we);
  - en_FIR=1 the cycle after in_we;
  - in_waddr increments after the write, wrapping 255->0;
  - zero_cnt cleared.
- WORKING, word_done, both channels 0:
  - write and pulse en_FIR as for a nonzero sample, and increment zero_cnt;
  - when zero_cnt reaches ZERO_LIMIT, that sample is still written and pulsed, then -> SLEEPING with sleep_flag=1 the same cycle as that en_FIR.
- SLEEPING:
  - all-zero words: no in_we, no en_FIR, in_waddr held.
  - first nonzero word: sleep_flag=0 in the in_we cycle, in_we plus en_FIR follow as in WORKING, zero_cnt=0, -> WORKING.
- en_FIR never coincides with sleep_flag rising except on the ZERO_LIMIT sample.
- zero_cnt is 10 bits and saturates at ZERO_LIMIT.
- Simultaneous Frame and word_done cannot occur (Frame is a first-bit marker). A Frame arriving mid-word in any state resynchronises without a write.
- Reset mid-load: returns to IDLE; the full rj/coeff reload is required.

Optional Feature:
- Macro: MEM_LOAD_SLEEP_EN
- Defined: sleep detection and the SLEEPING state as above.
- Undefined: zero_cnt removed, sleep_flag tied 0, every word in WORKING is written and pulses en_FIR, and the FSM never leaves WORKING except on reset.

Decomposition:
- Package mem_load_pkg: state enum (IDLE, LOAD_RJ, LOAD_COEFF, WORKING, SLEEPING; 3-bit), depth constants, address widths (4/9/8), ZERO_CNT_W=10.
- Sub-module sipo_word: shift register plus bit counter with Frame resync and word_done output. Instantiated once per channel, sharing Frame/bit_en.

Test Plan:
- Load 16 rj words 0x0001..0x0010 then 512 coeffs 0x0000..0x01FF -> rj_we 16 times at addresses 0..15, coeff_we 512 times at addresses 0..511, load_state reaches WORKING after the last coeff write.
- In WORKING, send sample L=0x1234, R=0xFEDC -> in_we at in_waddr=0 with that data, en_FIR one cycle later, in_waddr=1.
- Send 257 nonzero samples -> in_waddr wraps 255->0, and the 257th write goes to address 0.
- Send 800 zero samples then 5 zeros then L=0x0001 ->
  - 800 en_FIR pulses, with sleep_flag=1 alongside the 800th;
  - no writes or pulses for the 5 zeros;
  - the nonzero sample clears sleep_flag, writes at the next address and pulses en_FIR.
- Assert Frame after 7 bits of a word, then send a full word 0xA5A5 -> the partial word is discarded and exactly one write of 0xA5A5 occurs.
- Pulse Clear_n low mid-coefficient load (address 100) -> outputs 0 asynchronously, state IDLE, and the next Frame restarts the rj load at address 0.
